// File: rtl/sort_seq_pkg.sv
// Shared state encoding and default constants for the sort frame sequencer.
package sort_seq_pkg;

   typedef enum logic [1:0] {
      FEED = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2
   } seq_state_t;

   localparam int DW_DEF        = 3;
   localparam int FRAME_LEN_DEF = 4;
   localparam int TIMEOUT_DEF   = 16;

endpackage

// File: rtl/sort_seq_frame_counter.sv
// Element-in-frame counter: advances on each accepted sample and wraps after
// the last one, with combinational first/last decode of the current position.
module sort_seq_frame_counter #(
   parameter int FRAME_LEN = 4,
   parameter int CNT_W     = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             adv,
   output logic [CNT_W-1:0] cnt,
   output logic             first,
   output logic             last
);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

   assign first = (cnt == '0);
   assign last  = (cnt == LAST_IDX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   cnt <= '0;
      else if (adv) cnt <= last ? '0 : cnt + 1'b1;
   end

endmodule

// File: rtl/sort_frame_sequencer.sv
// Frames a sample stream for the max-compare engine and returns its result.
// Optional WAIT watchdog with res_err output: define SORT_SEQ_TIMEOUT_EN.
module sort_frame_sequencer
   import sort_seq_pkg::*;
#(
   parameter int DW        = DW_DEF,
   parameter int FRAME_LEN = FRAME_LEN_DEF,
   parameter int CNT_W     = 2
`ifdef SORT_SEQ_TIMEOUT_EN
   , parameter int TIMEOUT = TIMEOUT_DEF
`endif
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          eng_valid,
   output logic [DW-1:0] eng_data,
   output logic          eng_first,
   output logic          eng_last,
   input  logic          eng_done,
   input  logic [DW-1:0] eng_max,
   output logic          res_valid,
   input  logic          res_ready,
   output logic [DW-1:0] res_max,
`ifdef SORT_SEQ_TIMEOUT_EN
   output logic          res_err,
`endif
   output logic          busy
);

   seq_state_t       state, state_nxt;
   logic             accept;
   logic             timeout;
   logic [CNT_W-1:0] elem_cnt;
   logic             cnt_first, cnt_last;

   assign accept = in_valid && in_ready;

   sort_seq_frame_counter #(
      .FRAME_LEN (FRAME_LEN),
      .CNT_W     (CNT_W)
   ) u_frame_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .adv   (accept),
      .cnt   (elem_cnt),
      .first (cnt_first),
      .last  (cnt_last)
   );

`ifdef SORT_SEQ_TIMEOUT_EN
   localparam int WCNT_W = $clog2(TIMEOUT + 1);
   logic [WCNT_W-1:0] wait_cnt;

   // Counts completed WAIT cycles; zero in the first WAIT cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)             wait_cnt <= '0;
      else if (state != WAIT) wait_cnt <= '0;
      else                    wait_cnt <= wait_cnt + 1'b1;
   end

   // A done arriving on the deadline cycle takes priority over the timeout.
   assign timeout = (state == WAIT) && !eng_done && (wait_cnt == WCNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                         res_err <= 1'b0;
      else if (timeout)                   res_err <= 1'b1;
      else if (state == WAIT && eng_done) res_err <= 1'b0;
      else if (state == HOLD && res_ready) res_err <= 1'b0;
   end
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= FEED;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         FEED:    if (accept && cnt_last)    state_nxt = WAIT;
         WAIT:    if (eng_done || timeout)   state_nxt = HOLD;
         HOLD:    if (res_ready)             state_nxt = FEED;
         default:                            state_nxt = FEED;
      endcase
   end

   always_comb begin
      in_ready = (state == FEED);
      busy     = (state != FEED) || (elem_cnt != '0);
   end

   // Engine strobes lag the accept by one cycle; eng_data holds between samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         eng_valid <= 1'b0;
         eng_data  <= '0;
         eng_first <= 1'b0;
         eng_last  <= 1'b0;
      end else begin
         eng_valid <= accept;
         eng_first <= accept && cnt_first;
         eng_last  <= accept && cnt_last;
         if (accept) eng_data <= in_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_valid <= 1'b0;
         res_max   <= '0;
      end else if (state == WAIT && eng_done) begin
         res_valid <= 1'b1;
         res_max   <= eng_max;
      end else if (timeout) begin
         res_valid <= 1'b1;
         res_max   <= '0;
      end else if (state == HOLD && res_ready) begin
         res_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sort_frame_sequencer.sv
// Bench for sort_frame_sequencer: directed vector table, reset/watchdog
// sequences and a randomized run against a frame-level reference model.
module tb_sort_frame_sequencer;

   localparam int DW = 3;
   localparam int FL = 4;
   localparam int CW = 2;
   localparam int TO = 16;
`ifdef SORT_SEQ_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          eng_valid;
   logic [DW-1:0] eng_data;
   logic          eng_first;
   logic          eng_last;
   logic          eng_done;
   logic [DW-1:0] eng_max;
   logic          res_valid;
   logic          res_ready;
   logic [DW-1:0] res_max;
   logic          busy;
`ifdef SORT_SEQ_TIMEOUT_EN
   logic          res_err;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   sort_frame_sequencer #(
      .DW        (DW),
      .FRAME_LEN (FL),
      .CNT_W     (CW)
`ifdef SORT_SEQ_TIMEOUT_EN
      , .TIMEOUT (TO)
`endif
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .eng_valid (eng_valid),
      .eng_data  (eng_data),
      .eng_first (eng_first),
      .eng_last  (eng_last),
      .eng_done  (eng_done),
      .eng_max   (eng_max),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_max   (res_max),
`ifdef SORT_SEQ_TIMEOUT_EN
      .res_err   (res_err),
`endif
      .busy      (busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Frame-level reference model: samples collected in the current frame,
   // whether a result is awaited or pending, and the predicted outputs.
   int            m_n;
   bit            m_wait, m_hold, m_err;
   int            m_wcnt;
   logic [DW-1:0] m_rmax, m_ed, cur_max, frame_max;
   bit            m_ev, m_ef, m_el;

   task automatic model_reset();
      m_n = 0; m_wait = 0; m_hold = 0; m_err = 0; m_wcnt = 0;
      m_rmax = '0; m_ed = '0; cur_max = '0; frame_max = '0;
      m_ev = 0; m_ef = 0; m_el = 0;
   endtask

   task automatic model_step();
      bit acc;
      acc  = in_valid && !m_wait && !m_hold;
      m_ev = acc;
      m_ef = acc && (m_n == 0);
      m_el = acc && (m_n == FL - 1);
      if (acc) m_ed = in_data;
      if (m_wait) begin
         if (eng_done) begin
            m_rmax = eng_max; m_err = 0; m_hold = 1; m_wait = 0;
         end else if (TO_EN && m_wcnt == TO - 1) begin
            m_rmax = '0; m_err = 1; m_hold = 1; m_wait = 0;
         end else m_wcnt++;
      end else if (m_hold) begin
         if (res_ready) begin m_hold = 0; m_err = 0; end
      end else if (acc) begin
         cur_max = (m_n == 0 || in_data > cur_max) ? in_data : cur_max;
         m_n++;
         if (m_n == FL) begin
            m_n = 0; m_wait = 1; m_wcnt = 0; frame_max = cur_max;
         end
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".in_ready"},  32'(in_ready),  32'(!(m_wait || m_hold)));
      chk({tag, ".busy"},      32'(busy),      32'(m_wait || m_hold || m_n != 0));
      chk({tag, ".eng_valid"}, 32'(eng_valid), 32'(m_ev));
      chk({tag, ".eng_first"}, 32'(eng_first), 32'(m_ef));
      chk({tag, ".eng_last"},  32'(eng_last),  32'(m_el));
      if (m_ev) chk({tag, ".eng_data"}, 32'(eng_data), 32'(m_ed));
      chk({tag, ".res_valid"}, 32'(res_valid), 32'(m_hold));
      chk({tag, ".res_max"},   32'(res_max),   32'(m_rmax));
`ifdef SORT_SEQ_TIMEOUT_EN
      chk({tag, ".res_err"},   32'(res_err),   32'(m_err));
`endif
   endtask

   task automatic tick(input string tag);
      model_step();
      @(posedge clk);
      #1;
      check_model(tag);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".eng_valid"}, 32'(eng_valid), 32'd0);
      chk({tag, ".eng_data"},  32'(eng_data),  32'd0);
      chk({tag, ".eng_first"}, 32'(eng_first), 32'd0);
      chk({tag, ".eng_last"},  32'(eng_last),  32'd0);
      chk({tag, ".res_valid"}, 32'(res_valid), 32'd0);
      chk({tag, ".res_max"},   32'(res_max),   32'd0);
      chk({tag, ".in_ready"},  32'(in_ready),  32'd1);
      chk({tag, ".busy"},      32'(busy),      32'd0);
   endtask

   task automatic idle_inputs();
      in_valid = 0; in_data = '0; eng_done = 0; eng_max = '0; res_ready = 0;
   endtask

   typedef struct {
      logic          iv;
      logic [DW-1:0] d;
      logic          done;
      logic [DW-1:0] emax;
      logic          rr;
      logic          ev, ef, el;
      logic [DW-1:0] ed;
      logic          ir, rv;
      logic [DW-1:0] rm;
      logic          bz;
   } vec_t;

   function automatic vec_t mk(input logic iv, input logic [DW-1:0] d, input logic done,
                               input logic [DW-1:0] emax, input logic rr,
                               input logic ev, input logic ef, input logic el,
                               input logic [DW-1:0] ed, input logic ir, input logic rv,
                               input logic [DW-1:0] rm, input logic bz);
      vec_t v;
      v.iv = iv; v.d = d; v.done = done; v.emax = emax; v.rr = rr;
      v.ev = ev; v.ef = ef; v.el = el; v.ed = ed;
      v.ir = ir; v.rv = rv; v.rm = rm; v.bz = bz;
      return v;
   endfunction

   vec_t vec[$];

   initial begin
      int first_rv;

      //           iv d  dn mx rr | ev ef el ed ir rv rm bz
      // Frame 7,6,5,4 with done one cycle after the last strobe.
      vec.push_back(mk(1, 7, 0, 0, 0,  1, 1, 0, 7, 1, 0, 0, 1));
      vec.push_back(mk(1, 6, 0, 0, 0,  1, 0, 0, 6, 1, 0, 0, 1));
      vec.push_back(mk(1, 5, 0, 0, 0,  1, 0, 0, 5, 1, 0, 0, 1));
      vec.push_back(mk(1, 4, 0, 0, 0,  1, 0, 1, 4, 0, 0, 0, 1));
      vec.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1));
      vec.push_back(mk(0, 0, 1, 7, 0,  0, 0, 0, 0, 0, 1, 7, 1));
      // Result held while the consumer stalls; input pulses are refused.
      for (int i = 0; i < 5; i++)
         vec.push_back(mk(1'(i % 2 == 0), 3, 0, 0, 0,  0, 0, 0, 0, 0, 1, 7, 1));
      vec.push_back(mk(0, 0, 0, 0, 1,  0, 0, 0, 0, 1, 0, 7, 0));
      // Gapped frame 2,-,-,3,1,-,0; done in the same cycle as the last strobe.
      vec.push_back(mk(1, 2, 0, 0, 0,  1, 1, 0, 2, 1, 0, 7, 1));
      vec.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 7, 1));
      vec.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 7, 1));
      vec.push_back(mk(1, 3, 0, 0, 0,  1, 0, 0, 3, 1, 0, 7, 1));
      vec.push_back(mk(1, 1, 0, 0, 0,  1, 0, 0, 1, 1, 0, 7, 1));
      vec.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 7, 1));
      vec.push_back(mk(1, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0, 7, 1));
      vec.push_back(mk(0, 0, 1, 3, 0,  0, 0, 0, 0, 0, 1, 3, 1));
      vec.push_back(mk(0, 0, 0, 0, 1,  0, 0, 0, 0, 1, 0, 3, 0));
      // Stray done while feeding must be ignored.
      vec.push_back(mk(0, 0, 1, 6, 0,  0, 0, 0, 0, 1, 0, 3, 0));

      rst_n = 0;
      idle_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_reset("reset");
      rst_n = 1;

      foreach (vec[i]) begin
         in_valid = vec[i].iv; in_data = vec[i].d;
         eng_done = vec[i].done; eng_max = vec[i].emax; res_ready = vec[i].rr;
         model_step();
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d.eng_valid", i), 32'(eng_valid), 32'(vec[i].ev));
         chk($sformatf("vec%0d.eng_first", i), 32'(eng_first), 32'(vec[i].ef));
         chk($sformatf("vec%0d.eng_last", i),  32'(eng_last),  32'(vec[i].el));
         if (vec[i].ev) chk($sformatf("vec%0d.eng_data", i), 32'(eng_data), 32'(vec[i].ed));
         chk($sformatf("vec%0d.in_ready", i),  32'(in_ready),  32'(vec[i].ir));
         chk($sformatf("vec%0d.res_valid", i), 32'(res_valid), 32'(vec[i].rv));
         chk($sformatf("vec%0d.res_max", i),   32'(res_max),   32'(vec[i].rm));
         chk($sformatf("vec%0d.busy", i),      32'(busy),      32'(vec[i].bz));
      end
      idle_inputs();

      // Asynchronous reset after two accepted samples discards the frame.
      in_valid = 1; in_data = 2; tick("t4a");
      in_data = 3;               tick("t4b");
      idle_inputs();
      #3 rst_n = 0;
      #1 chk_reset("t4.async");
      model_reset();
      @(posedge clk);
      #1 rst_n = 1;
      foreach (vec[i]) if (i < 0) $display("unreachable");
      in_valid = 1; in_data = 5; tick("t4.f0");
      in_data = 1;               tick("t4.f1");
      in_data = 1;               tick("t4.f2");
      in_data = 1;               tick("t4.f3");
      in_valid = 0; eng_done = 1; eng_max = frame_max; tick("t4.done");
      chk("t4.res_max", 32'(res_max), 32'd5);
      eng_done = 0; res_ready = 1; tick("t4.take");
      res_ready = 0;

      // Silent engine: either the watchdog fires or WAIT persists.
      for (int i = 0; i < FL; i++) begin
         in_valid = 1; in_data = 3'(i); tick("t6.feed");
      end
      in_valid = 0;
      first_rv = -1;
      for (int i = 0; i < 100; i++) begin
         tick("t6.wait");
         if (res_valid && first_rv < 0) first_rv = i;
      end
`ifdef SORT_SEQ_TIMEOUT_EN
      chk("t6.timeout_cycle", 32'(first_rv), 32'(TO - 1));
      chk("t6.res_err", 32'(res_err), 32'd1);
      chk("t6.res_max", 32'(res_max), 32'd0);
      res_ready = 1; tick("t6.take");
      chk("t6.err_clear", 32'(res_err), 32'd0);
      res_ready = 0;
`else
      chk("t6.no_result", 32'(first_rv), 32'hFFFF_FFFF);
      chk("t6.in_ready", 32'(in_ready), 32'd0);
      chk("t6.busy", 32'(busy), 32'd1);
      eng_done = 1; eng_max = frame_max; tick("t6.late_done");
      eng_done = 0; res_ready = 1; tick("t6.take");
      res_ready = 0;
`endif

      // Randomized traffic: gaps, engine latency, stray dones, stalls.
      for (int c = 0; c < 800; c++) begin
         in_valid = ($urandom % 3) != 0;
         in_data  = 3'($urandom);
         if (m_wait) begin
            eng_done = ($urandom % 3) == 0;
            eng_max  = frame_max;
         end else begin
            eng_done = ($urandom % 8) == 0;
            eng_max  = 3'($urandom);
         end
         res_ready = ($urandom % 2) == 1;
         tick("rnd");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
